// File: rtl/npu_sched_pkg.sv
// ============================================================================
// Package : npu_sched_pkg
// Shared state encoding and defaults for the NPU job schedulers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package npu_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_START   = 3'd1;
    localparam state_t c_ST_WREQ    = 3'd2;
    localparam state_t c_ST_WAIT_WL = 3'd3;
    localparam state_t c_ST_WAIT_FE = 3'd4;
    localparam state_t c_ST_NEXT    = 3'd5;
    localparam state_t c_ST_DONE    = 3'd6;

    localparam logic [3:0]  c_PART_FULL_DEFAULT = 4'd8;
    localparam logic [12:0] c_JOB_CNT_MAX       = 13'd8191;

endpackage

`default_nettype wire

// File: rtl/dcs_idx_counter.sv
// ============================================================================
// Module  : dcs_idx_counter
// Nested piece/part loop counter; the part index is the inner loop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcs_idx_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] piece_max,
    input  logic [4:0] part_max,
    output logic [7:0] piece_idx,
    output logic [4:0] part_idx,
    output logic       last
);

    logic [7:0] r_piece;
    logic [4:0] r_part;
    logic       w_part_wrap;
    logic       w_piece_wrap;

    assign w_part_wrap  = (r_part == part_max);
    assign w_piece_wrap = (r_piece == piece_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_piece <= 8'd0;
            r_part  <= 5'd0;
        end else if (clear) begin
            r_piece <= 8'd0;
            r_part  <= 5'd0;
        end else if (step) begin
            if (w_part_wrap) begin
                r_part  <= 5'd0;
                r_piece <= w_piece_wrap ? 8'd0 : r_piece + 8'd1;
            end else begin
                r_part  <= r_part + 5'd1;
            end
        end
    end

    assign piece_idx = r_piece;
    assign part_idx  = r_part;
    assign last      = w_part_wrap && w_piece_wrap;

endmodule

`default_nettype wire

// File: rtl/depthconv_scheduler.sv
// ============================================================================
// Module  : depthconv_scheduler
// Sequences weight loads and feature sweeps over pieces x parts of a job.
// Revision: 1.0
// ============================================================================
`default_nettype none

module depthconv_scheduler
    import npu_sched_pkg::*;
#(
    parameter logic [3:0] PART_FULL = c_PART_FULL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  in_piece,
    input  logic [4:0]  part_num,
    input  logic [3:0]  last_part,
    input  logic        weight_load_end,
    input  logic        i_feature_end,
    output logic        start_calculate,
    output logic        o_wload_req,
    output logic [7:0]  o_piece_idx,
    output logic [4:0]  o_part_idx,
    output logic [3:0]  o_part_len,
    output logic [12:0] o_job_cnt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_in_piece;
    logic [4:0]  r_part_num;
    logic [3:0]  r_last_part;
    logic [12:0] r_job_cnt;
    logic        r_err;
    logic        w_clear;
    logic        w_step;
    logic        w_last;
    logic        w_empty;
    logic [7:0]  w_piece_max;
    logic [4:0]  w_part_max;

    assign w_empty     = (r_in_piece == 8'd0) || (r_part_num == 5'd0);
    assign w_piece_max = r_in_piece - 8'd1;
    assign w_part_max  = r_part_num - 5'd1;
    assign w_clear     = (r_state == c_ST_IDLE) && i_start;
    assign w_step      = (r_state == c_ST_NEXT) && !i_abort;

    dcs_idx_counter u_idx (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .step      (w_step),
        .piece_max (w_piece_max),
        .part_max  (w_part_max),
        .piece_idx (o_piece_idx),
        .part_idx  (o_part_idx),
        .last      (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over every other transition out of a busy state.
    always_comb begin
        w_next = r_state;
        if (r_state != c_ST_IDLE && i_abort) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (i_start) w_next = c_ST_START;
                c_ST_START:   w_next = w_empty ? c_ST_DONE : c_ST_WREQ;
                c_ST_WREQ:    w_next = c_ST_WAIT_WL;
                c_ST_WAIT_WL: if (weight_load_end) w_next = c_ST_WAIT_FE;
                c_ST_WAIT_FE: if (i_feature_end) w_next = c_ST_NEXT;
                c_ST_NEXT:    w_next = w_last ? c_ST_DONE : c_ST_WREQ;
                c_ST_DONE:    w_next = c_ST_IDLE;
                default:      w_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_calculate = (r_state == c_ST_START) && !w_empty;
        o_wload_req     = (r_state == c_ST_WREQ);
        o_done          = (r_state == c_ST_DONE);
        o_busy          = (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_piece  <= 8'd0;
            r_part_num  <= 5'd0;
            r_last_part <= 4'd0;
            r_job_cnt   <= 13'd0;
            r_err       <= 1'b0;
        end else if (w_clear) begin
            r_in_piece  <= in_piece;
            r_part_num  <= part_num;
            r_last_part <= last_part;
            r_job_cnt   <= 13'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_step && r_job_cnt != c_JOB_CNT_MAX) begin
                r_job_cnt <= r_job_cnt + 13'd1;
            end
            // A feature sweep finishing before its weights are loaded is a protocol error.
            if (r_state == c_ST_WAIT_WL && i_feature_end) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_part_len = (r_state == c_ST_IDLE) ? 4'd0 :
                        (o_part_idx == w_part_max) ? r_last_part : PART_FULL;
    assign o_job_cnt  = r_job_cnt;
    assign o_err      = r_err;

endmodule

`default_nettype wire

// File: doc/depthconv_scheduler.md
DEPTHCONV_SCHEDULER -- requirements
Module: depthconv_scheduler

Interface
REQ-001 SHALL have parameter PART_FULL, default 4'd8, meaning channels per non-final part.
REQ-002 SHALL have port clk  in  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_start  in  1  one-cycle job start pulse from decoder.
REQ-005 SHALL have port i_abort  in  1  synchronous job cancel.
REQ-006 SHALL have port in_piece  in  8  number of feature pieces per job.
REQ-007 SHALL have port part_num  in  5  number of channel parts per piece.
REQ-008 SHALL have port last_part  in  4  channel count of the final part.
REQ-009 SHALL have port weight_load_end  in  1  one-cycle pulse from WAGU when a weight load completes.
REQ-010 SHALL have port i_feature_end  in  1  one-cycle pulse from the depthwise IAGU when a part's feature sweep completes.
REQ-011 SHALL have port start_calculate  out  1  one-cycle pulse to the IAGU at job start.
REQ-012 SHALL have port o_wload_req  out  1  one-cycle weight-load request to WAGU.
REQ-013 SHALL have ports o_piece_idx  out  8 and o_part_idx  out  5, giving the current loop indices.
REQ-014 SHALL have port o_part_len  out  4, equal to last_part when o_part_idx==part_num-1 and PART_FULL otherwise.
REQ-015 SHALL have ports o_job_cnt  out  13 (parts completed in the current job), o_busy  out  1, o_done  out  1 (one-cycle pulse), and o_err  out  1 (sticky).

Function
REQ-016 SHALL implement FSM states IDLE, START, WREQ, WAIT_WL, WAIT_FE, NEXT, DONE.
REQ-017 In IDLE, i_start SHALL latch in_piece, part_num and last_part, clear indices, o_job_cnt and o_err, and go to START; the latched values SHALL be used for the whole job.
REQ-018 On i_start with latched in_piece==0 or part_num==0, the FSM SHALL go directly to DONE: o_done one cycle later, no start_calculate, no o_wload_req.
REQ-019 START SHALL assert start_calculate for exactly one cycle, then go to WREQ.
REQ-020 WREQ SHALL assert o_wload_req for exactly one cycle, then go to WAIT_WL.
REQ-021 WAIT_WL SHALL hold until weight_load_end, then go to WAIT_FE.
REQ-022 WAIT_FE SHALL hold until i_feature_end, then go to NEXT.
REQ-023 i_feature_end sampled in WAIT_WL, including in the same cycle as weight_load_end, SHALL set o_err and SHALL NOT count as completion of the part.
REQ-024 NEXT SHALL increment o_job_cnt and advance the indices: the part index wraps to 0 at part_num-1 and the piece index then increments. If both were at their maxima, the FSM SHALL go to DONE; otherwise it SHALL go to WREQ.
REQ-025 DONE SHALL assert o_done for one cycle, then go to IDLE.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 i_start while not in IDLE SHALL be ignored.
REQ-028 i_abort in any non-IDLE state SHALL force IDLE on the next edge with no o_done; i_abort has priority over all other transitions.
REQ-029 weight_load_end or i_feature_end outside WAIT_WL/WAIT_FE SHALL be ignored, apart from REQ-023.
REQ-030 o_job_cnt SHALL be 13-bit unsigned and SHALL saturate at 8191.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, with all outputs and indices 0, o_part_len 0, and o_err 0.
REQ-032 Reset asserted mid-job SHALL discard the job; after release, no pulse output SHALL fire until a new i_start.

Structure
REQ-033 The state encoding and PART_FULL default SHALL live in the shared package npu_sched_pkg.
REQ-034 The nested piece/part counter SHALL be a sub-module dcs_idx_counter with inputs clear, step, piece_max and part_max, and outputs piece_idx, part_idx and last.

Verification
REQ-035 Test: in_piece=2, part_num=2, last_part=2, weight_load_end 3 cycles after each o_wload_req, i_feature_end 5 cycles later -> 1 start_calculate, 4 o_wload_req, index sequence (0,0),(0,1),(1,0),(1,1), o_part_len 8,2,8,2, o_job_cnt=4, then o_done.
REQ-036 Test: in_piece=0 -> o_done 2 cycles after i_start, with start_calculate and o_wload_req never asserted.
REQ-037 Test: weight_load_end and i_feature_end in the same cycle in WAIT_WL -> o_err=1, FSM in WAIT_FE; a later i_feature_end completes the part.
REQ-038 Test: i_abort during WAIT_FE of part 1 -> IDLE next cycle, o_busy=0, no o_done; a new job then runs normally.
REQ-039 Test: rst low during WAIT_WL -> all outputs 0 immediately; stray weight_load_end after release -> no response.
REQ-040 Test: second i_start while busy -> ignored, with latched parameters unchanged and the job result identical to the first scenario.
